// File: rtl/multi_channel_freq_divider.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_freq_divider
// Brief    : N independent run-time programmable dividers, each producing a
//            one-cycle tick strobe, a 50% square wave and a busy flag.
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_freq_divider #(
    parameter int CLK_HZ      = 50000000,
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 27,
    parameter int DEFAULT_DIV = CLK_HZ,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [CNT_W-1:0]    wr_div,
    input  logic                wr_mode,
    input  logic [CHANNELS-1:0] ch_en,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] sqw,
    output logic [CHANNELS-1:0] busy
);

    localparam logic [CNT_W-1:0] c_default_div = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_zero        = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t             r_state, w_state_nx;
        logic [CNT_W-1:0]   r_div,   w_div_nx;
        logic [CNT_W-1:0]   r_cnt,   w_cnt_nx;
        logic               r_mode,  w_mode_nx;
        logic               r_tick,  w_tick_nx;
        logic               r_sqw,   w_sqw_nx;
        logic               r_busy;
        logic               w_hit;
        logic               w_tc;

        // Out-of-range channel numbers never match any index, so they are dropped here.
        assign w_hit = wr_en && (wr_ch == CH_W'(i));
        assign w_tc  = (r_cnt == (r_div - c_one));

        always_comb begin
            w_state_nx = r_state;
            w_div_nx   = r_div;
            w_mode_nx  = r_mode;
            w_cnt_nx   = r_cnt;
            w_tick_nx  = 1'b0;
            w_sqw_nx   = r_sqw;

            if (w_hit) begin
                // A write restarts the channel and overrides a coincident terminal count.
                w_div_nx   = wr_div;
                w_mode_nx  = wr_mode;
                w_cnt_nx   = c_zero;
                w_sqw_nx   = 1'b0;
                w_state_nx = (ch_en[i] && (wr_div != c_zero)) ? ST_RUN : ST_IDLE;
            end else if (!ch_en[i]) begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = c_zero;
                w_sqw_nx   = 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        w_cnt_nx = c_zero;
                        w_sqw_nx = 1'b0;
                        if (r_div != c_zero) begin
                            w_state_nx = ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (r_div == c_zero) begin
                            w_state_nx = ST_IDLE;
                            w_cnt_nx   = c_zero;
                            w_sqw_nx   = 1'b0;
                        end else if (w_tc) begin
                            w_cnt_nx  = c_zero;
                            w_tick_nx = 1'b1;
                            w_sqw_nx  = ~r_sqw;
                            if (r_mode) begin
                                w_state_nx = ST_DONE;
                            end
                        end else begin
                            w_cnt_nx = r_cnt + c_one;
                        end
                    end
                    ST_DONE: begin
                        w_cnt_nx = c_zero;
                    end
                    default: begin
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = c_zero;
                        w_sqw_nx   = 1'b0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_IDLE;
                r_div   <= c_default_div;
                r_mode  <= 1'b0;
                r_cnt   <= c_zero;
                r_tick  <= 1'b0;
                r_sqw   <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                r_state <= w_state_nx;
                r_div   <= w_div_nx;
                r_mode  <= w_mode_nx;
                r_cnt   <= w_cnt_nx;
                r_tick  <= w_tick_nx;
                r_sqw   <= w_sqw_nx;
                r_busy  <= (w_state_nx == ST_RUN);
            end
        end

        assign tick[i] = r_tick;
        assign sqw[i]  = r_sqw;
        assign busy[i] = r_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_freq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_freq_divider
// Brief    : Directed, table-driven bench for multi_channel_freq_divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_channel_freq_divider;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_ch = '0;
    logic [7:0] wr_div = '0;
    logic       wr_mode = 1'b0;
    logic [3:0] ch_en = '0;
    logic [3:0] tick, sqw, busy;

    // 3-channel instance for out-of-range writes
    logic       b_rst = 1'b1;
    logic       b_wr_en = 1'b0;
    logic [1:0] b_wr_ch = '0;
    logic [7:0] b_wr_div = '0;
    logic       b_wr_mode = 1'b0;
    logic [2:0] b_ch_en = '0;
    logic [2:0] b_tick, b_sqw, b_busy;

    multi_channel_freq_divider #(
        .CLK_HZ(50000000), .CHANNELS(4), .CNT_W(8), .DEFAULT_DIV(10)
    ) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
        .wr_mode(wr_mode), .ch_en(ch_en), .tick(tick), .sqw(sqw), .busy(busy)
    );

    multi_channel_freq_divider #(
        .CLK_HZ(50000000), .CHANNELS(3), .CNT_W(8), .DEFAULT_DIV(10)
    ) u_dut_b (
        .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_ch(b_wr_ch), .wr_div(b_wr_div),
        .wr_mode(b_wr_mode), .ch_en(b_ch_en), .tick(b_tick), .sqw(b_sqw), .busy(b_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rst;
        logic [3:0] en;
        logic [3:0] tick;
        logic [3:0] sqw;
        logic [3:0] busy;
    } vec_t;

    vec_t tbl[32];

    task automatic drive(input logic r, input logic we, input logic [1:0] ch,
                         input logic [7:0] dv, input logic md, input logic [3:0] en);
        rst = r; wr_en = we; wr_ch = ch; wr_div = dv; wr_mode = md; ch_en = en;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic idle(input logic [3:0] en);
        drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, en);
    endtask

    task automatic chk(input string name, input logic [3:0] et, input logic [3:0] es,
                       input logic [3:0] eb);
        n_tests++;
        if (tick !== et || sqw !== es || busy !== eb) begin
            n_fail++;
            $display("FAIL %s: got tick=%b sqw=%b busy=%b, want tick=%b sqw=%b busy=%b",
                     name, tick, sqw, busy, et, es, eb);
        end
    endtask

    task automatic drive_b(input logic r, input logic we, input logic [1:0] ch,
                           input logic [7:0] dv, input logic [2:0] en);
        b_rst = r; b_wr_en = we; b_wr_ch = ch; b_wr_div = dv; b_wr_mode = 1'b0; b_ch_en = en;
        @(posedge clk);
        #1;
        b_wr_en = 1'b0;
    endtask

    task automatic chk_b(input string name, input logic [2:0] et, input logic [2:0] es,
                         input logic [2:0] eb);
        n_tests++;
        if (b_tick !== et || b_sqw !== es || b_busy !== eb) begin
            n_fail++;
            $display("FAIL %s: got tick=%b sqw=%b busy=%b, want tick=%b sqw=%b busy=%b",
                     name, b_tick, b_sqw, b_busy, et, es, eb);
        end
    endtask

    initial begin
        // Entry 0 is reset, entry 1 is the enable edge; ticks land 10, 20, 30 edges later.
        tbl[0] = '{rst: 1'b1, en: 4'b0000, tick: 4'b0000, sqw: 4'b0000, busy: 4'b0000};
        for (int k = 1; k < 32; k++) begin
            tbl[k].rst  = 1'b0;
            tbl[k].en   = 4'b0001;
            tbl[k].tick = (k == 11 || k == 21 || k == 31) ? 4'b0001 : 4'b0000;
            tbl[k].sqw  = ((k >= 11 && k <= 20) || k == 31) ? 4'b0001 : 4'b0000;
            tbl[k].busy = 4'b0001;
        end

        @(posedge clk);
        #1;

        // Reset default, table-driven
        for (int k = 0; k < 32; k++) begin
            drive(tbl[k].rst, 1'b0, 2'd0, 8'd0, 1'b0, tbl[k].en);
            chk($sformatf("default_div_cycle%0d", k), tbl[k].tick, tbl[k].sqw, tbl[k].busy);
        end

        // Runtime write: ch2 div=3, then div=5 mid-count
        drive(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000);
        chk("rst_before_write", 4'b0000, 4'b0000, 4'b0000);
        drive(1'b0, 1'b1, 2'd2, 8'd3, 1'b0, 4'b0100);
        chk("wr_div3_edge", 4'b0000, 4'b0000, 4'b0100);
        for (int k = 1; k <= 10; k++) begin
            idle(4'b0100);
            chk($sformatf("div3_cycle%0d", k), (k % 3 == 0) ? 4'b0100 : 4'b0000,
                ((k >= 3 && k < 6) || k >= 9) ? 4'b0100 : 4'b0000, 4'b0100);
        end
        drive(1'b0, 1'b1, 2'd2, 8'd5, 1'b0, 4'b0100);
        chk("wr_div5_midcount", 4'b0000, 4'b0000, 4'b0100);
        for (int k = 1; k <= 5; k++) begin
            idle(4'b0100);
            chk($sformatf("div5_cycle%0d", k), (k == 5) ? 4'b0100 : 4'b0000,
                (k == 5) ? 4'b0100 : 4'b0000, 4'b0100);
        end

        // One-shot on ch1
        drive(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000);
        drive(1'b0, 1'b1, 2'd1, 8'd4, 1'b1, 4'b0010);
        chk("oneshot_start", 4'b0000, 4'b0000, 4'b0010);
        for (int k = 1; k <= 3; k++) begin
            idle(4'b0010);
            chk($sformatf("oneshot_wait%0d", k), 4'b0000, 4'b0000, 4'b0010);
        end
        idle(4'b0010);
        chk("oneshot_tick", 4'b0010, 4'b0010, 4'b0000);
        for (int k = 1; k <= 50; k++) begin
            idle(4'b0010);
            chk($sformatf("oneshot_done%0d", k), 4'b0000, 4'b0010, 4'b0000);
        end
        idle(4'b0000);
        chk("oneshot_disable", 4'b0000, 4'b0000, 4'b0000);
        idle(4'b0010);
        chk("oneshot_rearm", 4'b0000, 4'b0000, 4'b0010);
        for (int k = 1; k <= 6; k++) begin
            idle(4'b0010);
            chk($sformatf("oneshot2_cycle%0d", k), (k == 4) ? 4'b0010 : 4'b0000,
                (k >= 4) ? 4'b0010 : 4'b0000, (k >= 4) ? 4'b0000 : 4'b0010);
        end

        // div=1, then write of 0 while running
        drive(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000);
        drive(1'b0, 1'b1, 2'd0, 8'd1, 1'b0, 4'b0001);
        chk("div1_start", 4'b0000, 4'b0000, 4'b0001);
        for (int k = 1; k <= 6; k++) begin
            idle(4'b0001);
            chk($sformatf("div1_cycle%0d", k), 4'b0001, (k % 2 == 1) ? 4'b0001 : 4'b0000, 4'b0001);
        end
        drive(1'b0, 1'b1, 2'd0, 8'd0, 1'b0, 4'b0001);
        chk("div0_write_in_run", 4'b0000, 4'b0000, 4'b0000);
        for (int k = 1; k <= 3; k++) begin
            idle(4'b0001);
            chk($sformatf("div0_idle%0d", k), 4'b0000, 4'b0000, 4'b0000);
        end

        // Write landing on a terminal-count edge of ch3
        drive(1'b0, 1'b1, 2'd3, 8'd4, 1'b0, 4'b1001);
        chk("tcwr_start", 4'b0000, 4'b0000, 4'b1000);
        for (int k = 1; k <= 7; k++) begin
            idle(4'b1001);
            chk($sformatf("tcwr_cycle%0d", k), (k == 4) ? 4'b1000 : 4'b0000,
                (k >= 4) ? 4'b1000 : 4'b0000, 4'b1000);
        end
        drive(1'b0, 1'b1, 2'd3, 8'd4, 1'b0, 4'b1001);
        chk("tcwr_collide", 4'b0000, 4'b0000, 4'b1000);
        for (int k = 1; k <= 4; k++) begin
            idle(4'b1001);
            chk($sformatf("tcwr_after%0d", k), (k == 4) ? 4'b1000 : 4'b0000,
                (k == 4) ? 4'b1000 : 4'b0000, 4'b1000);
        end

        // Disable ch0 at counter=7 on its second period
        drive(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000);
        idle(4'b0001);
        chk("dis_enable", 4'b0000, 4'b0000, 4'b0001);
        for (int j = 1; j <= 17; j++) begin
            idle(4'b0001);
            chk($sformatf("dis_cycle%0d", j), (j == 10) ? 4'b0001 : 4'b0000,
                (j >= 10) ? 4'b0001 : 4'b0000, 4'b0001);
        end
        for (int j = 0; j < 4; j++) begin
            idle(4'b0000);
            chk($sformatf("dis_off%0d", j), 4'b0000, 4'b0000, 4'b0000);
        end

        // Reset while all channels run; div of ch1 returns to 10
        drive(1'b0, 1'b1, 2'd1, 8'd3, 1'b0, 4'b1111);
        chk("rstmid_start", 4'b0000, 4'b0000, 4'b1111);
        for (int j = 1; j <= 5; j++) begin
            idle(4'b1111);
            chk($sformatf("rstmid_run%0d", j), (j == 3) ? 4'b0010 : 4'b0000,
                (j >= 3) ? 4'b0010 : 4'b0000, 4'b1111);
        end
        drive(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 4'b1111);
        chk("rstmid_reset", 4'b0000, 4'b0000, 4'b0000);
        idle(4'b1111);
        chk("rstmid_restart", 4'b0000, 4'b0000, 4'b1111);
        for (int j = 1; j <= 10; j++) begin
            idle(4'b1111);
            chk($sformatf("rstmid_div10_%0d", j), (j == 10) ? 4'b1111 : 4'b0000,
                (j == 10) ? 4'b1111 : 4'b0000, 4'b1111);
        end

        // Out-of-range writes on the 3-channel instance
        drive_b(1'b1, 1'b0, 2'd0, 8'd0, 3'b000);
        chk_b("oor_reset", 3'b000, 3'b000, 3'b000);
        drive_b(1'b0, 1'b1, 2'd0, 8'd4, 3'b111);
        chk_b("oor_start", 3'b000, 3'b000, 3'b111);
        for (int j = 1; j <= 12; j++) begin
            if (j == 3 || j == 8) begin
                drive_b(1'b0, 1'b1, 2'd3, 8'd0, 3'b111);
            end else begin
                drive_b(1'b0, 1'b0, 2'd0, 8'd0, 3'b111);
            end
            chk_b($sformatf("oor_cycle%0d", j),
                  {(j == 10), (j == 10), (j % 4 == 0)},
                  {(j >= 10), (j >= 10), ((j >= 4 && j < 8) || j >= 12)},
                  3'b111);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_channel_freq_divider.md
Name: multi_channel_freq_divider

Overview:
- Parametrised N-channel successor to the single fixed-ratio divider. Each channel has its own divisor, mode and enable.
- Each channel produces a one-cycle `tick` strobe and a 50%-duty square wave `sqw`.
- Divisors are loaded at run time through a simple write port.
- Sits between the 50 MHz board clock and slow consumers: LED blinkers, display multiplexers, debouncers, timers.
- All outputs are registered and stay in the `clk` domain. No derived clocks are generated.

Parameters:
- CLK_HZ, 50000000, input clock frequency. Documentation and default-divisor calculation only.
- CHANNELS, 4, number of independent divider channels (1..16).
- CNT_W, 27, width of divisor and counter per channel.
- DEFAULT_DIV, CLK_HZ, divisor loaded into every channel at reset (1 s tick at 50 MHz). Must fit in CNT_W bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  write strobe for the divisor/mode registers.
- wr_ch  in  $clog2(CHANNELS) (min 1)  target channel of the write.
- wr_div  in  CNT_W  new divisor value.
- wr_mode  in  1  0 = periodic, 1 = one-shot.
- ch_en  in  CHANNELS  per-channel run enable (level).
- tick  out  CHANNELS  one-cycle strobe at each terminal count.
- sqw  out  CHANNELS  square wave, toggles at each terminal count (period 2*div).
- busy  out  CHANNELS  1 while the channel is in RUN.

Behaviour:
- Reset (rst=1 at a posedge), every channel:
  - div=DEFAULT_DIV, mode=periodic, counter=0, state=IDLE.
  - tick=0, sqw=0, busy=0.
  - Reset mid-count aborts immediately; no tick is issued.
- Per-channel FSM, evaluated independently:
  - IDLE: counter=0, sqw=0, busy=0. Go to RUN when ch_en=1 and div!=0.
  - RUN: busy=1, counter increments each cycle.
    - When counter==div-1: counter wraps to 0, tick=1 next cycle, sqw toggles.
    - If mode=one-shot, go to DONE on that same edge.
  - DONE: busy=0, tick=0, sqw holds its last value, counter=0.
    - Go to IDLE when ch_en=0.
    - Go to RUN on a write to this channel while ch_en=1.
  - Any state with ch_en=0: next state IDLE, counter=0, sqw=0, no tick.
- Timing:
  - First tick is high in the cycle after the div-th posedge in RUN. Periodic mode then repeats every div cycles.
  - The edge that sees ch_en rise moves IDLE->RUN with counter=0. The channel then counts 0..div-1.
  - div=1: tick continuously high in RUN, sqw toggles every cycle.
  - div=0: channel never leaves IDLE. A write of 0 while in RUN forces IDLE.
- Write port:
  - On posedge with wr_en=1 and wr_ch<CHANNELS, the channel's div and mode are updated.
  - In the same edge, the channel's counter clears to 0 and sqw clears to 0. State becomes RUN if ch_en=1 and wr_div!=0, else IDLE.
  - wr_ch>=CHANNELS: write ignored, no state change anywhere.
  - Write and terminal count on the same channel in the same cycle: write wins, no tick, no sqw toggle.
  - Other channels are unaffected by a write.
- Arithmetic: counter is unsigned CNT_W bits. Comparison is against div-1 computed in CNT_W bits; the div=0 case is excluded by the FSM.
- tick, sqw and busy are driven from flops, with no combinational path from inputs.

Test Plan:
- Reset default: CHANNELS=4, CNT_W=8, DEFAULT_DIV=10. Release rst, ch_en=4'b0001 -> tick[0] high one cycle every 10 cycles, first at cycle 10 after enable; sqw[0] period 20; tick[3:1]=0, busy=4'b0001.
- Runtime write: write ch2 div=3 periodic, ch_en[2]=1 -> tick[2] every 3 cycles. Write ch2 div=5 mid-count -> counter restarts, next tick exactly 5 cycles after the write edge, sqw[2] back to 0.
- One-shot: write ch1 div=4 mode=1, ch_en[1]=1 -> exactly one tick 4 cycles later, busy[1] falls with it, no further ticks for 50 cycles. Drop then raise ch_en[1] -> a second single tick.
- Boundaries: div=1 -> tick[0] constant 1, sqw[0] toggling every cycle. div=0 -> busy=0, tick=0. Write landing on a terminal-count cycle -> no tick that cycle.
- Disable and reset mid-operation: ch_en[0] dropped at counter=7 of 10 -> next cycle busy=0, sqw=0, no tick. rst pulsed while all channels run -> all outputs 0 the next cycle and div back to 10.
- Out-of-range write: CHANNELS=3, wr_ch=3 -> no channel's div, counter or outputs change.
